// File: rtl/lt24_touch_pkg.sv
// LT24 touch controller shared definitions: FSM states,
// register map, CTRL bit positions and ADS7843 command bytes.
package lt24_touch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CS_SETUP,
      S_CMD,
      S_WAIT_BUSY,
      S_DATA,
      S_NEXT,
      S_DONE,
      S_GAP
   } state_e;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_X    = 2'd1;
   localparam logic [1:0] REG_Y    = 2'd2;
   localparam logic [1:0] REG_CNT  = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQEN  = 1;
   localparam int CTRL_PEN    = 2;
   localparam int CTRL_VALID  = 3;
   localparam int CTRL_TERR   = 4;
   localparam int CTRL_ACTIVE = 5;

   localparam logic [7:0] ADS_CMD_X = 8'hD3;
   localparam logic [7:0] ADS_CMD_Y = 8'h93;

endpackage

// File: rtl/lt24_touch_spi_shift.sv
// SCLK divider plus 8-bit command / 16-bit data shifter.
// len_i=0 shifts cmd_i out MSB-first, len_i=1 clocks 16 bits in.
module lt24_touch_spi_shift #(
   parameter int CLK_DIV = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        len_i,
   input  logic [7:0]  cmd_i,
   input  logic        abort_i,
   input  logic        dout_i,
   output logic        tick_o,
   output logic        done_o,
   output logic [11:0] rdata_o,
   output logic        sclk_o,
   output logic        din_o
);

   localparam int DW = $clog2(CLK_DIV);

   logic [DW-1:0] div_q;
   logic          act_q;
   logic          sclk_q;
   logic          din_q;
   logic          len_q;
   logic [4:0]    bits_q;
   logic [15:0]   sh_q;

   assign tick_o  = (div_q == DW'(CLK_DIV - 1));
   assign done_o  = tick_o & act_q & sclk_q & (bits_q == 5'd1) & ~abort_i;
   assign rdata_o = sh_q[15:4];
   assign sclk_o  = sclk_q;
   assign din_o   = din_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         act_q  <= 1'b0;
         sclk_q <= 1'b0;
         din_q  <= 1'b0;
         len_q  <= 1'b0;
         bits_q <= '0;
         sh_q   <= '0;
      end else begin
         div_q <= tick_o ? '0 : div_q + DW'(1);
         if (abort_i) begin
            act_q  <= 1'b0;
            sclk_q <= 1'b0;
            din_q  <= 1'b0;
         end else if (start_i && !act_q) begin
            act_q  <= 1'b1;
            len_q  <= len_i;
            bits_q <= len_i ? 5'd16 : 5'd8;
            sh_q   <= {cmd_i, 8'h00};
            din_q  <= ~len_i & cmd_i[7];
            sclk_q <= 1'b0;
         end else if (tick_o && act_q) begin
            if (!sclk_q) begin
               sclk_q <= 1'b1;
            end else begin
               // falling tick: sample ADC bit, present next command bit
               sclk_q <= 1'b0;
               sh_q   <= {sh_q[14:0], dout_i};
               bits_q <= bits_q - 5'd1;
               if (bits_q == 5'd1) begin
                  act_q <= 1'b0;
                  din_q <= 1'b0;
               end else begin
                  din_q <= ~len_q & sh_q[14];
               end
            end
         end
      end
   end

endmodule

// File: rtl/lt24_touch_ctrl.sv
// Avalon-MM LT24 touch controller: sequences X/Y conversions on
// pen-down and publishes each coherent pair with valid/count/irq.
module lt24_touch_ctrl
   import lt24_touch_pkg::*;
#(
   parameter int         CLK_DIV      = 25,
   parameter logic [7:0] CMD_X        = ADS_CMD_X,
   parameter logic [7:0] CMD_Y        = ADS_CMD_Y,
   parameter int         BUSY_TIMEOUT = 1023,
   parameter int         GAP_CYCLES   = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        touch_sclk,
   output logic        touch_cs_n,
   output logic        touch_din,
   input  logic        touch_dout,
   input  logic        touch_busy,
   input  logic        touch_penirq_n
);

   localparam int TMAX = (GAP_CYCLES > BUSY_TIMEOUT) ?
                         GAP_CYCLES : BUSY_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);

   state_e        state_q;
   logic [1:0]    dout_sq, busy_sq, pen_sq;
   logic          en_q, irqen_q, valid_q, terr_q;
   logic          cs_n_q, pass_q;
   logic [TW-1:0] tmr_q;
   logic [11:0]   x_q, y_q, shx_q, shy_q;
   logic [15:0]   cnt_q, cnt_d;
   logic [31:0]   rd_q, rd_d;
   logic          spi_start_q, spi_len_q;
   logic [7:0]    spi_cmd_q;
   logic          tick, spi_done, abort, upd;
   logic          pen_down, busy_s;
   logic [11:0]   spi_rdata;
   logic          ctrl_wr;
   logic          unused_wd;

   assign pen_down  = ~pen_sq[1];
   assign busy_s    = busy_sq[1];
   assign ctrl_wr   = write & (address == REG_CTRL);
   assign unused_wd = ^{writedata[31:5], writedata[2]};

   assign abort = tick & ~en_q &
                  (state_q != S_IDLE) & (state_q != S_GAP);
   assign upd   = (state_q == S_DONE) & pen_down & ~abort;
   assign cnt_d = cnt_q + {15'd0, upd};

   assign readdata   = rd_q;
   assign irq        = valid_q & irqen_q;
   assign touch_cs_n = cs_n_q;

   lt24_touch_spi_shift #(
      .CLK_DIV (CLK_DIV)
   ) u_spi (
      .clk     (clk),
      .rst     (reset),
      .start_i (spi_start_q),
      .len_i   (spi_len_q),
      .cmd_i   (spi_cmd_q),
      .abort_i (abort),
      .dout_i  (dout_sq[1]),
      .tick_o  (tick),
      .done_o  (spi_done),
      .rdata_o (spi_rdata),
      .sclk_o  (touch_sclk),
      .din_o   (touch_din)
   );

   always_comb begin
      rd_d = '0;
      unique case (address)
         REG_CTRL: begin
            rd_d[CTRL_EN]     = en_q;
            rd_d[CTRL_IRQEN]  = irqen_q;
            rd_d[CTRL_PEN]    = pen_down;
            rd_d[CTRL_VALID]  = valid_q;
            rd_d[CTRL_TERR]   = terr_q;
            rd_d[CTRL_ACTIVE] = (state_q != S_IDLE);
         end
         REG_X:   rd_d[11:0] = x_q;
         REG_Y:   rd_d[11:0] = y_q;
         REG_CNT: rd_d[15:0] = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         dout_sq     <= '0;
         busy_sq     <= '0;
         pen_sq      <= 2'b11;
         en_q        <= 1'b0;
         irqen_q     <= 1'b0;
         valid_q     <= 1'b0;
         terr_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         pass_q      <= 1'b0;
         tmr_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         shx_q       <= '0;
         shy_q       <= '0;
         cnt_q       <= '0;
         rd_q        <= '0;
         spi_start_q <= 1'b0;
         spi_len_q   <= 1'b0;
         spi_cmd_q   <= '0;
      end else begin
         dout_sq     <= {dout_sq[0], touch_dout};
         busy_sq     <= {busy_sq[0], touch_busy};
         pen_sq      <= {pen_sq[0], touch_penirq_n};
         cnt_q       <= cnt_d;
         spi_start_q <= 1'b0;
         if (read) rd_q <= rd_d;
         // w1c first so a same-cycle set from the FSM below wins
         if (ctrl_wr) begin
            en_q    <= writedata[CTRL_EN];
            irqen_q <= writedata[CTRL_IRQEN];
            if (writedata[CTRL_VALID]) valid_q <= 1'b0;
            if (writedata[CTRL_TERR])  terr_q  <= 1'b0;
         end
         if (abort) begin
            cs_n_q  <= 1'b1;
            pass_q  <= 1'b0;
            state_q <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: if (en_q && pen_down) begin
                  cs_n_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  state_q <= S_CS_SETUP;
               end
               S_CS_SETUP: if (tick) begin
                  spi_start_q <= 1'b1;
                  spi_len_q   <= 1'b0;
                  spi_cmd_q   <= CMD_X;
                  state_q     <= S_CMD;
               end
               S_CMD: if (spi_done) begin
                  tmr_q   <= '0;
                  state_q <= S_WAIT_BUSY;
               end
               S_WAIT_BUSY: begin
                  if (!busy_s) begin
                     spi_start_q <= 1'b1;
                     spi_len_q   <= 1'b1;
                     state_q     <= S_DATA;
                  end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
                     terr_q  <= 1'b1;
                     cs_n_q  <= 1'b1;
                     pass_q  <= 1'b0;
                     tmr_q   <= '0;
                     state_q <= S_GAP;
                  end else begin
                     tmr_q <= tmr_q + TW'(1);
                  end
               end
               S_DATA: if (spi_done) state_q <= S_NEXT;
               S_NEXT: begin
                  if (!pass_q) begin
                     shx_q       <= spi_rdata;
                     pass_q      <= 1'b1;
                     spi_start_q <= 1'b1;
                     spi_len_q   <= 1'b0;
                     spi_cmd_q   <= CMD_Y;
                     state_q     <= S_CMD;
                  end else begin
                     shy_q   <= spi_rdata;
                     state_q <= S_DONE;
                  end
               end
               S_DONE: begin
                  cs_n_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  tmr_q   <= '0;
                  state_q <= S_GAP;
                  if (upd) begin
                     x_q     <= shx_q;
                     y_q     <= shy_q;
                     valid_q <= 1'b1;
                  end
               end
               S_GAP: begin
                  if (tmr_q == TW'(GAP_CYCLES - 1)) state_q <= S_IDLE;
                  else tmr_q <= tmr_q + TW'(1);
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lt24_touch_ctrl.sv
// Bench for lt24_touch_ctrl with a behavioural ADS7843 model
// and a read scoreboard driven from vector tables.
module tb_lt24_touch_ctrl;
   import lt24_touch_pkg::*;

   localparam int CLK_DIV  = 4;
   localparam int GAP      = 300;
   localparam int BUSY_LAT = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq;
   logic        touch_sclk, touch_cs_n, touch_din;
   logic        touch_dout = 1'b0;
   logic        touch_busy;
   logic        touch_penirq_n = 1'b1;

   always #5 clk = ~clk;

   lt24_touch_ctrl #(
      .CLK_DIV    (CLK_DIV),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .address        (address),
      .read           (read),
      .write          (write),
      .writedata      (writedata),
      .readdata       (readdata),
      .irq            (irq),
      .touch_sclk     (touch_sclk),
      .touch_cs_n     (touch_cs_n),
      .touch_din      (touch_din),
      .touch_dout     (touch_dout),
      .touch_busy     (touch_busy),
      .touch_penirq_n (touch_penirq_n)
   );

   // ADC model: 8 command bits, busy, then 16 data bits per frame
   longint unsigned cyc = 0;
   longint unsigned busy_until = 0;
   logic            hold_busy = 1'b0;
   int              bc = 0;
   int              mp, mfr, mj;
   logic [7:0]      sh8 = '0;
   logic [11:0]     mv;
   logic [7:0]      cmd_log[$];
   logic [11:0]     model_x = '0, model_y = '0;

   always @(posedge clk) cyc <= cyc + 1;
   assign touch_busy = hold_busy | (cyc < busy_until);

   always @(posedge touch_sclk or posedge touch_cs_n) begin
      if (touch_cs_n) begin
         bc = 0;
         touch_dout = 1'b0;
         busy_until = 0;
      end else begin
         mp  = bc % 24;
         mfr = bc / 24;
         if (mp < 8) begin
            if (mp == 0) begin
               busy_until = 64'hFFFF_FFFF_FFFF_FFFF;
               sh8 = '0;
            end
            sh8 = {sh8[6:0], touch_din};
            if (mp == 7) begin
               cmd_log.push_back(sh8);
               busy_until = cyc + BUSY_LAT;
            end
         end else begin
            mj = mp - 8;
            mv = (mfr == 0) ? model_x : model_y;
            touch_dout = (mj < 12) ? mv[11-mj] : 1'b0;
         end
         bc = bc + 1;
      end
   end

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   vec_t        rst_v[4];
   vec_t        smp_v[4];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a;
      writedata = d;
      write = 1'b1;
      @(posedge clk);
      #1;
      write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e,
                     input string nm);
      logic [31:0] ex;
      address = a;
      read = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      read = 1'b0;
      ex = exp_q.pop_front();
      chk(nm, readdata, ex);
   endtask

   task automatic wait_irq(input int maxc, input string nm);
      int k = 0;
      while (!irq && k < maxc) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(nm, 32'(irq), 32'd1);
   endtask

   task automatic wait_bc(input int minv, input int maxc,
                          input string nm);
      int k = 0;
      while (bc < minv && k < maxc) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(nm, 32'(bc >= minv), 32'd1);
   endtask

   task automatic count_cs(input int maxc, output int n);
      n = 0;
      while (!touch_cs_n && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int base;
      int n;
      rst_v[0] = '{REG_CTRL, 32'h0, "rst_ctrl"};
      rst_v[1] = '{REG_X,    32'h0, "rst_x"};
      rst_v[2] = '{REG_Y,    32'h0, "rst_y"};
      rst_v[3] = '{REG_CNT,  32'h0, "rst_cnt"};
      smp_v[0] = '{REG_X,    32'hABC, "smp_x"};
      smp_v[1] = '{REG_Y,    32'h345, "smp_y"};
      smp_v[2] = '{REG_CNT,  32'h1,   "smp_cnt"};
      smp_v[3] = '{REG_CTRL, 32'h2F,  "smp_ctrl"};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_cs_n", 32'(touch_cs_n), 32'd1);
      chk("rst_sclk", 32'(touch_sclk), 32'd0);
      chk("rst_din", 32'(touch_din), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      for (int i = 0; i < 4; i++)
         rd(rst_v[i].addr, rst_v[i].exp, rst_v[i].nm);

      // normal pair
      model_x = 12'hABC;
      model_y = 12'h345;
      base = cmd_log.size();
      touch_penirq_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      wr(REG_CTRL, 32'h3);
      wait_irq(4000, "irq_set");
      chk("cmd_count", 32'(cmd_log.size() - base), 32'd2);
      if (cmd_log.size() >= base + 2) begin
         chk("cmd_x", 32'(cmd_log[base]), 32'hD3);
         chk("cmd_y", 32'(cmd_log[base+1]), 32'h93);
      end
      for (int i = 0; i < 4; i++)
         rd(smp_v[i].addr, smp_v[i].exp, smp_v[i].nm);
      wr(REG_CTRL, 32'h0B);
      rd(REG_CTRL, 32'h27, "ctrl_w1c");
      chk("irq_clr", 32'(irq), 32'd0);
      wr(REG_CTRL, 32'h0);
      repeat (GAP + 50) @(posedge clk);
      #1;
      rd(REG_CTRL, 32'h04, "ctrl_idle");

      // busy stuck high
      hold_busy = 1'b1;
      wr(REG_CTRL, 32'h1);
      wait_bc(8, 500, "bc_cmd_x");
      n = 0;
      while (touch_sclk && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      count_cs(2000, n);
      chk("timeout_cycles", 32'(n), 32'd1023);
      rd(REG_CTRL, 32'h35, "ctrl_terr");
      rd(REG_X, 32'hABC, "to_x");
      rd(REG_Y, 32'h345, "to_y");
      wr(REG_CTRL, 32'h10);
      hold_busy = 1'b0;
      repeat (GAP + 50) @(posedge clk);
      #1;
      rd(REG_CTRL, 32'h04, "ctrl_terr_clr");

      // pen lifted during Y data
      model_x = 12'h123;
      model_y = 12'h456;
      wr(REG_CTRL, 32'h1);
      wait_bc(35, 3000, "bc_y_data");
      touch_penirq_n = 1'b1;
      count_cs(1000, n);
      chk("discard_cs", 32'(touch_cs_n), 32'd1);
      rd(REG_CTRL, 32'h21, "ctrl_discard");
      rd(REG_CNT, 32'h1, "cnt_discard");
      rd(REG_X, 32'hABC, "x_discard");
      rd(REG_Y, 32'h345, "y_discard");
      wr(REG_CTRL, 32'h0);
      repeat (GAP + 50) @(posedge clk);
      #1;

      // enable cleared during X command
      touch_penirq_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      wr(REG_CTRL, 32'h1);
      wait_bc(3, 500, "bc_abort");
      wr(REG_CTRL, 32'h0);
      count_cs(100, n);
      chk("abort_latency", 32'(n <= CLK_DIV), 32'd1);
      chk("abort_sclk", 32'(touch_sclk), 32'd0);
      rd(REG_CTRL, 32'h04, "ctrl_abort");
      rd(REG_CNT, 32'h1, "cnt_abort");

      // sample counter wrap
      force dut.cnt_q = 16'hFFFF;
      repeat (3) @(posedge clk);
      release dut.cnt_q;
      repeat (2) @(posedge clk);
      #1;
      rd(REG_CNT, 32'hFFFF, "cnt_preload");
      model_x = 12'h0F0;
      model_y = 12'hF0F;
      wr(REG_CTRL, 32'h3);
      wait_irq(4000, "irq_wrap");
      rd(REG_CNT, 32'h0, "cnt_wrap");
      rd(REG_X, 32'h0F0, "x_wrap");
      rd(REG_Y, 32'hF0F, "y_wrap");
      wr(REG_CTRL, 32'h08);
      repeat (GAP + 50) @(posedge clk);
      #1;

      // asynchronous reset mid-transfer
      wr(REG_CTRL, 32'h1);
      wait_bc(4, 500, "bc_reset");
      #2;
      reset = 1'b1;
      #1;
      chk("arst_cs_n", 32'(touch_cs_n), 32'd1);
      chk("arst_sclk", 32'(touch_sclk), 32'd0);
      chk("arst_din", 32'(touch_din), 32'd0);
      chk("arst_rdata", readdata, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rd(REG_CTRL, 32'h04, "ctrl_after_rst");
      rd(REG_CNT, 32'h0, "cnt_after_rst");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
